// File: rtl/layer_link_serializer_if.sv
// Link between an upstream parallel layer and the serializer feeding the next layer.
// master = upstream/configuration side, slave = the serializer.
interface layer_link_serializer_if #(
  parameter int N_PARALLEL      = 30,
  parameter int DATA_WIDTH      = 16,
  parameter int LANES           = 1,
  parameter int NUM_NEXT_NEURON = 30
);
  logic [N_PARALLEL*DATA_WIDTH-1:0] i_data;
  logic                             i_valid;
  logic                             o_ready;
  logic [NUM_NEXT_NEURON-1:0]       i_next_ready;
  logic [31:0]                      i_layer_id;
  logic [31:0]                      i_neuron_id;
  logic [LANES*DATA_WIDTH-1:0]      o_data;
  logic                             o_valid;
  logic                             o_last;
  logic                             o_drop;

  modport master (
    output i_data, i_valid, i_next_ready, i_layer_id, i_neuron_id,
    input  o_ready, o_data, o_valid, o_last, o_drop
  );

  modport slave (
    input  i_data, i_valid, i_next_ready, i_layer_id, i_neuron_id,
    output o_ready, o_data, o_valid, o_last, o_drop
  );
endinterface

// File: rtl/layer_link_serializer.sv
// Captures a layer's parallel output into a 1- or 2-slot vector FIFO and streams it
// LANES elements per beat, selecting the downstream ready and flagging dropped vectors.
module layer_link_serializer #(
  parameter int N_PARALLEL      = 30,
  parameter int DATA_WIDTH      = 16,
  parameter int LANES           = 1,
  parameter int NUM_NEXT_NEURON = 30,
  parameter int NEXT_LAYER_ID   = 2,
  parameter int DOUBLE_BUFFER   = 1
) (
  input logic                    i_clk,
  input logic                    i_reset,
  layer_link_serializer_if.slave link
);
  localparam int DEPTH  = (DOUBLE_BUFFER != 0) ? 2 : 1;
  localparam int BEATS  = N_PARALLEL / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int NID_W  = (NUM_NEXT_NEURON > 1) ? $clog2(NUM_NEXT_NEURON) : 1;

  localparam logic [1:0]        DEPTH_C   = 2'(DEPTH);
  localparam logic              LAST_PTR  = 1'(DEPTH - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  // A vector viewed as beats, so the current beat is a plain index.
  typedef logic [BEATS-1:0][LANES*DATA_WIDTH-1:0] vec_t;

  vec_t              mem [DEPTH];
  vec_t              head;
  logic              wr_ptr, wr_ptr_nxt;
  logic              rd_ptr, rd_ptr_nxt;
  logic [1:0]        count, count_nxt;
  logic [BEAT_W-1:0] beat, beat_nxt;
  logic              drop, drop_nxt;
  logic              valid, ready, rdy_eff, take, xfer, fin;

  assign valid = (count != 2'd0);
  assign ready = (count < DEPTH_C);
  assign head  = mem[rd_ptr];

  assign link.o_valid = valid;
  assign link.o_ready = ready;
  assign link.o_last  = valid && (beat == LAST_BEAT);
  assign link.o_drop  = drop;
  assign link.o_data  = valid ? head[beat] : '0;

  // While the next layer loads weights only the neuron being configured gates the link.
  always_comb begin
    rdy_eff = &link.i_next_ready;
    if (link.i_layer_id == 32'(NEXT_LAYER_ID))
      rdy_eff = (link.i_neuron_id < 32'(NUM_NEXT_NEURON)) &&
                link.i_next_ready[link.i_neuron_id[NID_W-1:0]];
  end

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    take       = link.i_valid && ready;
    xfer       = valid && rdy_eff;
    fin        = xfer && (beat == LAST_BEAT);
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    beat_nxt   = beat;
    drop_nxt   = drop | (link.i_valid && !ready);

    if (take) wr_ptr_nxt = (wr_ptr == LAST_PTR) ? 1'b0 : ~wr_ptr;
    if (fin) begin
      rd_ptr_nxt = (rd_ptr == LAST_PTR) ? 1'b0 : ~rd_ptr;
      beat_nxt   = '0;
    end else if (xfer) begin
      beat_nxt   = beat + 1'b1;
    end

    if (take && !fin)      count_nxt = count + 2'd1;
    else if (!take && fin) count_nxt = count - 2'd1;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      beat   <= '0;
      drop   <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      beat   <= beat_nxt;
      drop   <= drop_nxt;
    end
  end

  // NOTE: slot storage is not reset; o_data is gated by o_valid so it still reads 0 after reset.
  always_ff @(posedge i_clk) begin
    if (take) mem[wr_ptr] <= link.i_data;
  end
endmodule

// File: tb/tb_layer_link_serializer.sv
// Drives three serializer configurations with shared stimulus and checks each against a
// queue-based model of the link, plus directed literal checks from the test plan.
module tb_layer_link_serializer;
  localparam int NP   = 4;
  localparam int DW   = 8;
  localparam int NNN  = 30;
  localparam int NLID = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NP*DW-1:0]  data;
  logic              valid;
  logic [NNN-1:0]    nrdy;
  logic [31:0]       lid, nid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready as the link should see it.
  function automatic bit eff_ready(input logic [NNN-1:0] nr, input logic [31:0] l,
                                   input logic [31:0] n);
    logic [NNN-1:0] sh;
    if (l == 32'(NLID)) begin
      if (n >= 32'(NNN)) return 1'b0;
      sh = nr >> n;
      return sh[0];
    end
    return &nr;
  endfunction

  // cfg0: LANES=1 double buffer, cfg1: LANES=2 double buffer, cfg2: LANES=1 single buffer
  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int L     = (g == 1) ? 2 : 1;
    localparam int DB    = (g == 2) ? 0 : 1;
    localparam int DEPTH = (DB != 0) ? 2 : 1;
    localparam int BEATS = NP / L;
    localparam int LW    = L * DW;

    layer_link_serializer_if #(.N_PARALLEL(NP), .DATA_WIDTH(DW), .LANES(L),
                               .NUM_NEXT_NEURON(NNN)) link ();

    assign link.i_data       = data;
    assign link.i_valid      = valid;
    assign link.i_next_ready = nrdy;
    assign link.i_layer_id   = lid;
    assign link.i_neuron_id  = nid;

    layer_link_serializer #(
      .N_PARALLEL(NP), .DATA_WIDTH(DW), .LANES(L), .NUM_NEXT_NEURON(NNN),
      .NEXT_LAYER_ID(NLID), .DOUBLE_BUFFER(DB)
    ) dut (
      .i_clk  (clk),
      .i_reset(rst),
      .link   (link.slave)
    );

    logic [NP*DW-1:0] q[$];
    int               beat = 0;
    bit               drop = 1'b0;

    // Model: queued vectors, beat within the head vector, sticky drop.
    initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        beat = 0;
        drop = 1'b0;
      end else begin : upd
        bit r, v, room;
        r    = eff_ready(nrdy, lid, nid);
        v    = (q.size() > 0);
        room = (q.size() < DEPTH);
        if (v && r) begin
          if (beat == BEATS - 1) begin
            void'(q.pop_front());
            beat = 0;
          end else begin
            beat++;
          end
        end
        if (valid) begin
          if (room) q.push_back(data);
          else      drop = 1'b1;
        end
      end
    end

    initial forever begin
      @(negedge clk);
      begin : cmp
        logic [NP*DW-1:0] hv;
        logic [LW-1:0]    exp_d;
        bit               v;
        v     = (q.size() > 0);
        hv    = v ? q[0] : '0;
        exp_d = v ? LW'(hv >> (beat * LW)) : '0;
        check($sformatf("cfg%0d o_valid", g), 64'(link.o_valid), 64'(v));
        check($sformatf("cfg%0d o_ready", g), 64'(link.o_ready), 64'(q.size() < DEPTH));
        check($sformatf("cfg%0d o_drop", g),  64'(link.o_drop),  64'(drop));
        check($sformatf("cfg%0d o_last", g),  64'(link.o_last),  64'(v && (beat == BEATS - 1)));
        check($sformatf("cfg%0d o_data", g),  64'(link.o_data),  64'(exp_d));
      end
    end
  end

  task automatic send(input logic [NP*DW-1:0] v);
    @(posedge clk); #1;
    valid = 1'b1;
    data  = v;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [NP*DW-1:0] VA = 32'h04030201;
  localparam logic [NP*DW-1:0] VB = 32'h14131211;
  localparam logic [NP*DW-1:0] VC = 32'h24232221;

  initial begin
    logic [7:0] bp_pat [5];
    logic       bp_bit [4];
    valid = 1'b0;
    data  = '0;
    nrdy  = '1;
    lid   = 32'd1;
    nid   = 32'd0;
    #1 rst = 1'b1;
    idle(2);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset o_ready", 64'(g_cfg[0].link.o_ready), 64'd1);
    check("reset o_valid", 64'(g_cfg[0].link.o_valid), 64'd0);
    check("reset o_drop",  64'(g_cfg[0].link.o_drop),  64'd0);
    check("reset o_data",  64'(g_cfg[0].link.o_data),  64'd0);

    // Single vector, LANES=1 and LANES=2
    send(VA);
    @(negedge clk);
    check("l1 beat0", 64'(g_cfg[0].link.o_data), 64'h01);
    check("l2 beat0", 64'(g_cfg[1].link.o_data), 64'h0201);
    check("l2 last0", 64'(g_cfg[1].link.o_last), 64'd0);
    @(negedge clk);
    check("l1 beat1", 64'(g_cfg[0].link.o_data), 64'h02);
    check("l2 beat1", 64'(g_cfg[1].link.o_data), 64'h0403);
    check("l2 last1", 64'(g_cfg[1].link.o_last), 64'd1);
    @(negedge clk);
    check("l1 beat2", 64'(g_cfg[0].link.o_data), 64'h03);
    @(negedge clk);
    check("l1 beat3", 64'(g_cfg[0].link.o_data), 64'h04);
    check("l1 last3", 64'(g_cfg[0].link.o_last), 64'd1);
    check("l1 ready", 64'(g_cfg[0].link.o_ready), 64'd1);
    idle(3);

    // Back-to-back A, B, then C while both slots are held
    @(posedge clk); #1;
    valid = 1'b1; data = VA;
    @(posedge clk); #1;
    data = VB;
    @(posedge clk); #1;
    data = VC;
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    check("db full ready", 64'(g_cfg[0].link.o_ready), 64'd0);
    check("db drop",       64'(g_cfg[0].link.o_drop),  64'd1);
    check("db a beat2",    64'(g_cfg[0].link.o_data),  64'h03);
    @(negedge clk);
    @(negedge clk);
    check("db b beat0",    64'(g_cfg[0].link.o_data),  64'h11);
    idle(8);

    // Per-neuron backpressure during weight load
    lid = 32'd2;
    nid = 32'd3;
    send(VA);
    bp_bit  = '{1'b1, 1'b0, 1'b0, 1'b1};
    bp_pat  = '{8'h01, 8'h02, 8'h02, 8'h02, 8'h03};
    for (int i = 0; i < 4; i++) begin
      nrdy[3] = bp_bit[i];
      @(negedge clk);
      check($sformatf("bp cycle%0d", i), 64'(g_cfg[0].link.o_data), 64'(bp_pat[i]));
      @(posedge clk); #1;
    end
    nid = 32'd40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp nid40 hold%0d", i), 64'(g_cfg[0].link.o_data), 64'(bp_pat[4]));
      @(posedge clk); #1;
    end
    nid = 32'd3;
    idle(6);

    // Outside load phase: AND of all ready bits
    lid  = 32'd1;
    nrdy = '1;
    nrdy[7] = 1'b0;
    send(VB);
    @(negedge clk);
    check("and stall0", 64'(g_cfg[0].link.o_data), 64'h11);
    @(negedge clk);
    check("and stall1", 64'(g_cfg[0].link.o_data), 64'h11);
    @(posedge clk); #1;
    nrdy = '1;
    @(negedge clk);
    check("and stall2", 64'(g_cfg[0].link.o_data), 64'h11);
    @(negedge clk);
    check("and stream", 64'(g_cfg[0].link.o_data), 64'h12);
    idle(6);

    // Reset mid-stream with a second vector queued
    @(posedge clk); #1;
    valid = 1'b1; data = VA;
    @(posedge clk); #1;
    data = VB;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst o_valid now", 64'(g_cfg[0].link.o_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst o_ready", 64'(g_cfg[0].link.o_ready), 64'd1);
    check("rst o_drop",  64'(g_cfg[0].link.o_drop),  64'd0);
    send(VC);
    @(negedge clk);
    check("rst restart beat0", 64'(g_cfg[0].link.o_data), 64'h21);
    idle(6);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      valid = ($urandom_range(0, 2) == 0);
      data  = $urandom;
      nrdy  = ($urandom_range(0, 3) == 0) ? NNN'($urandom) : '1;
      lid   = 32'($urandom_range(1, 3));
      case ($urandom_range(0, 4))
        0:       nid = 32'd40;
        1:       nid = 32'd30;
        2:       nid = 32'd29;
        default: nid = 32'($urandom_range(0, 29));
      endcase
      rst = ($urandom_range(0, 499) == 0);
    end
    @(posedge clk); #1;
    rst   = 1'b0;
    valid = 1'b0;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/layer_link_serializer.md
# layer_link_serializer

Parametrised inter-layer link between two fully-parallel neural-network layers. It captures one layer's N_PARALLEL-wide output vector and streams it to the next layer as LANES elements per beat, with an optional second capture slot so a new vector can be accepted while the previous one is still draining. It folds in ready selection for the next layer (per-neuron ready while that layer loads weights), drives a `last` marker, and flags dropped vectors. It replaces the fixed single-element serializer plus separate ready-mux pair between every layer pair of the top level.

## Interface
- N_PARALLEL, 30: elements per input vector; must be a multiple of LANES.
- DATA_WIDTH, 16: bits per element.
- LANES, 1: elements per output beat.
- NUM_NEXT_NEURON, 30: width of the next layer's ready vector.
- NEXT_LAYER_ID, 2: layer id of the downstream layer.
- DOUBLE_BUFFER, 1: 1 gives two capture slots; 0 gives one.

Ports:
- i_clk  in  1  clock; one clock domain, everything on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_data  in  N_PARALLEL*DATA_WIDTH  input vector; element k is in bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_valid  in  1  input vector valid (a one-cycle pulse from the upstream layer).
- o_ready  out  1  a capture slot is free.
- i_next_ready  in  NUM_NEXT_NEURON  ready bits from the next layer's neurons.
- i_layer_id  in  32  layer id currently being configured.
- i_neuron_id  in  32  neuron id currently being configured.
- o_data  out  LANES*DATA_WIDTH  output beat; lane 0 is in the LSBs.
- o_valid  out  1  output beat valid.
- o_last  out  1  marks the final beat of a vector.
- o_drop  out  1  sticky: a vector arrived while no slot was free.

## Operation
- DEPTH = DOUBLE_BUFFER ? 2 : 1. BEATS = N_PARALLEL/LANES.
- Storage is a FIFO of DEPTH vector slots, with a write pointer, a read pointer, an occupancy count (0..DEPTH) and a beat index (0..BEATS-1).
- o_ready = (count < DEPTH). It is a function of registered state only.
- Capture:
  - When i_valid && o_ready, the whole i_data is written to the slot at the write pointer.
  - The write pointer advances, wrapping at DEPTH, and count increments.
- Drop:
  - When i_valid && !o_ready, i_data is discarded and o_drop is set.
  - o_drop clears only on reset.
- Effective downstream ready, rdy_eff:
  - If i_layer_id == NEXT_LAYER_ID: rdy_eff = i_next_ready[i_neuron_id] when i_neuron_id < NUM_NEXT_NEURON, otherwise 0.
  - Otherwise: rdy_eff = AND of all bits of i_next_ready.
- Output signals:
  - o_valid = (count > 0).
  - o_data = elements beat*LANES .. beat*LANES+LANES-1 of the slot at the read pointer.
  - o_last = o_valid && (beat == BEATS-1).
- Transfer occurs on o_valid && rdy_eff:
  - Not the final beat: beat increments.
  - Final beat: beat goes to 0, the read pointer advances (wrapping), and count decrements.
- Simultaneous capture and final-beat transfer:
  - count is unchanged.
  - Both pointers move.
  - The new vector streams right after the old one.
- States, implied by count and beat: EMPTY (count 0), STREAM (count ≥ 1), FULL (count == DEPTH, o_ready low).
- Holding o_valid low mid-vector is not allowed. Once valid, o_data/o_last hold stable until transferred.

## Timing
- Reset values: o_valid 0, o_last 0, o_drop 0, o_ready 1, all pointers/count/beat 0. o_data contents are don't-care but must be deterministic (0).
- Reset asserted mid-stream aborts all buffered vectors immediately, with no further beats.
- Latency: a vector captured at edge N has its beat 0 valid after edge N.
- Throughput: one beat per cycle with rdy_eff held high. With DOUBLE_BUFFER=1 there are zero idle cycles between back-to-back vectors.
- Throughput with DOUBLE_BUFFER=0: o_ready returns high the cycle after the final-beat transfer. An i_valid arriving in the same cycle as that final-beat transfer is dropped.
- rdy_eff is combinational from its inputs; o_valid/o_data/o_last/o_ready/o_drop are registered-state outputs.
- i_layer_id/i_neuron_id changes take effect in the same cycle's rdy_eff.

## Test plan
- N_PARALLEL=4, DATA_WIDTH=8, LANES=1, vector elements 0..3 = 01,02,03,04, rdy_eff=1 -> beats 01,02,03,04 on 4 consecutive cycles starting the cycle after capture; o_last only on 04; o_ready stays 1.
- LANES=2, same vector -> beats 16'h0201, 16'h0403; o_last on the second beat.
- DOUBLE_BUFFER=1:
  - Inputs: vectors A=(01..04), B=(11..14) one cycle apart, a third vector C while both slots are occupied.
  - Required: 01..04 then 11..14 with no gap; o_ready low while 2 slots are held; C discarded and o_drop=1 until reset.
- Backpressure: i_layer_id=NEXT_LAYER_ID=2, i_neuron_id=3, i_next_ready bit 3 toggled 1,0,0,1 -> beat advances only on cycles with bit 3 = 1; o_data stable otherwise. i_neuron_id=40 (NUM_NEXT_NEURON=30) -> no transfer.
- Outside the load phase: i_layer_id=1, i_next_ready all ones except one bit -> stalls; all ones -> streams.
- Reset pulse after beat 1 of a 4-beat vector with a second vector queued -> o_valid 0 the same cycle; after release o_ready=1, o_drop=0; next capture starts at beat 0.
